// File: rtl/wb_reg_writer.sv
// Write-back stage writer: registers access-stage GPR/CSR writes, merges buffered
// long-latency results and tracks pending GPR writes. Optional macro: WB_CSR_WR_EN.
module wb_reg_writer #(
    parameter int unsigned BUF_DEPTH      = 2,
    parameter int unsigned CPU_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      as_reg_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] as_reg_wr_adder_i,
    input  logic [CPU_WIDTH-1:0]      as_reg_wr_data_i,
    input  logic                      as_csr_wr_en_i,
    input  logic [CSR_ADDR_WIDTH-1:0] as_csr_wr_adder_i,
    input  logic [CPU_WIDTH-1:0]      as_csr_wr_data_i,
    input  logic                      ll_issue_i,
    input  logic [REG_ADDR_WIDTH-1:0] ll_issue_adder_i,
    input  logic                      ll_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ll_adder_i,
    input  logic [CPU_WIDTH-1:0]      ll_data_i,
    output logic                      ll_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] reg1_rd_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg2_rd_adder_i,
    output logic                      reg1_pend_o,
    output logic                      reg2_pend_o,
    output logic                      wb_reg_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_adder_o,
    output logic [CPU_WIDTH-1:0]      wb_reg_wr_data_o,
    output logic                      wb_csr_wr_en_o,
    output logic [CSR_ADDR_WIDTH-1:0] wb_csr_wr_adder_o,
    output logic [CPU_WIDTH-1:0]      wb_csr_wr_data_o
);

    localparam int unsigned PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] adder;
        logic [CPU_WIDTH-1:0]      data;
    } ll_entry_t;

    ll_entry_t                 buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [CNT_W-1:0]          count;
    logic [NUM_REGS-1:0]       pend;

    logic                      as_gpr_req;
    logic                      push;
    logic                      pop;
    ll_entry_t                 head;
    logic [NUM_REGS-1:0]       pend_next;
    logic                      wb_en_next;
    logic [REG_ADDR_WIDTH-1:0] wb_adder_next;
    logic [CPU_WIDTH-1:0]      wb_data_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered count, so a pop never opens a slot the same cycle.
    assign ll_ready_o = (count < CNT_W'(BUF_DEPTH));

    assign reg1_pend_o = pend[reg1_rd_adder_i];
    assign reg2_pend_o = pend[reg2_rd_adder_i];

    // x0 writes are treated as no request / not buffered.
    assign as_gpr_req = as_reg_wr_en_i && (as_reg_wr_adder_i != '0);
    assign push       = ll_valid_i && ll_ready_o && (ll_adder_i != '0);
    assign pop        = !as_gpr_req && (count != '0);
    assign head       = buf_mem[rd_ptr];

    // GPR write port selection: access stage first, then buffer head.
    always_comb begin
        wb_en_next    = 1'b0;
        wb_adder_next = wb_reg_wr_adder_o;
        wb_data_next  = wb_reg_wr_data_o;
        if (as_gpr_req) begin
            wb_en_next    = 1'b1;
            wb_adder_next = as_reg_wr_adder_i;
            wb_data_next  = as_reg_wr_data_i;
        end else if (pop) begin
            wb_en_next    = 1'b1;
            wb_adder_next = head.adder;
            wb_data_next  = head.data;
        end
    end

    // Scoreboard update; a new issue overrides a same-cycle clear.
    always_comb begin
        pend_next = pend;
        if (pop) begin
            pend_next[head.adder] = 1'b0;
        end
        if (ll_issue_i && (ll_issue_adder_i != '0)) begin
            pend_next[ll_issue_adder_i] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            pend              <= '0;
            wb_reg_wr_en_o    <= 1'b0;
            wb_reg_wr_adder_o <= '0;
            wb_reg_wr_data_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            pend              <= pend_next;
            wb_reg_wr_en_o    <= wb_en_next;
            wb_reg_wr_adder_o <= wb_adder_next;
            wb_reg_wr_data_o  <= wb_data_next;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= '{adder: ll_adder_i, data: ll_data_i};
        end
    end

`ifdef WB_CSR_WR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_csr_wr_en_o    <= 1'b0;
            wb_csr_wr_adder_o <= '0;
            wb_csr_wr_data_o  <= '0;
        end else begin
            wb_csr_wr_en_o    <= as_csr_wr_en_i;
            wb_csr_wr_adder_o <= as_csr_wr_adder_i;
            wb_csr_wr_data_o  <= as_csr_wr_data_i;
        end
    end
`else
    logic unused_csr;
    assign unused_csr        = ^{as_csr_wr_en_i, as_csr_wr_adder_i, as_csr_wr_data_i};
    assign wb_csr_wr_en_o    = 1'b0;
    assign wb_csr_wr_adder_o = '0;
    assign wb_csr_wr_data_o  = '0;
`endif

endmodule

// File: tb/tb_wb_reg_writer.sv
// Directed self-checking bench for wb_reg_writer (default parameters).
module tb_wb_reg_writer;

    localparam int unsigned CW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned SW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          as_reg_wr_en_i;
    logic [RW-1:0] as_reg_wr_adder_i;
    logic [CW-1:0] as_reg_wr_data_i;
    logic          as_csr_wr_en_i;
    logic [SW-1:0] as_csr_wr_adder_i;
    logic [CW-1:0] as_csr_wr_data_i;
    logic          ll_issue_i;
    logic [RW-1:0] ll_issue_adder_i;
    logic          ll_valid_i;
    logic [RW-1:0] ll_adder_i;
    logic [CW-1:0] ll_data_i;
    logic          ll_ready_o;
    logic [RW-1:0] reg1_rd_adder_i;
    logic [RW-1:0] reg2_rd_adder_i;
    logic          reg1_pend_o;
    logic          reg2_pend_o;
    logic          wb_reg_wr_en_o;
    logic [RW-1:0] wb_reg_wr_adder_o;
    logic [CW-1:0] wb_reg_wr_data_o;
    logic          wb_csr_wr_en_o;
    logic [SW-1:0] wb_csr_wr_adder_o;
    logic [CW-1:0] wb_csr_wr_data_o;

    int checks   = 0;
    int failures = 0;

    wb_reg_writer dut (
        .clk               (clk),
        .rst               (rst),
        .as_reg_wr_en_i    (as_reg_wr_en_i),
        .as_reg_wr_adder_i (as_reg_wr_adder_i),
        .as_reg_wr_data_i  (as_reg_wr_data_i),
        .as_csr_wr_en_i    (as_csr_wr_en_i),
        .as_csr_wr_adder_i (as_csr_wr_adder_i),
        .as_csr_wr_data_i  (as_csr_wr_data_i),
        .ll_issue_i        (ll_issue_i),
        .ll_issue_adder_i  (ll_issue_adder_i),
        .ll_valid_i        (ll_valid_i),
        .ll_adder_i        (ll_adder_i),
        .ll_data_i         (ll_data_i),
        .ll_ready_o        (ll_ready_o),
        .reg1_rd_adder_i   (reg1_rd_adder_i),
        .reg2_rd_adder_i   (reg2_rd_adder_i),
        .reg1_pend_o       (reg1_pend_o),
        .reg2_pend_o       (reg2_pend_o),
        .wb_reg_wr_en_o    (wb_reg_wr_en_o),
        .wb_reg_wr_adder_o (wb_reg_wr_adder_o),
        .wb_reg_wr_data_o  (wb_reg_wr_data_o),
        .wb_csr_wr_en_o    (wb_csr_wr_en_o),
        .wb_csr_wr_adder_o (wb_csr_wr_adder_o),
        .wb_csr_wr_data_o  (wb_csr_wr_data_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        as_reg_wr_en_i    = 1'b0;
        as_reg_wr_adder_i = '0;
        as_reg_wr_data_i  = '0;
        as_csr_wr_en_i    = 1'b0;
        as_csr_wr_adder_i = '0;
        as_csr_wr_data_i  = '0;
        ll_issue_i        = 1'b0;
        ll_issue_adder_i  = '0;
        ll_valid_i        = 1'b0;
        ll_adder_i        = '0;
        ll_data_i         = '0;
        reg1_rd_adder_i   = '0;
        reg2_rd_adder_i   = '0;
    endtask

    task automatic as_write(input logic [RW-1:0] a, input logic [CW-1:0] d);
        as_reg_wr_en_i    = 1'b1;
        as_reg_wr_adder_i = a;
        as_reg_wr_data_i  = d;
    endtask

    task automatic ll_result(input logic [RW-1:0] a, input logic [CW-1:0] d);
        ll_valid_i = 1'b1;
        ll_adder_i = a;
        ll_data_i  = d;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reg1_rd_adder_i = RW'(7);
        reg2_rd_adder_i = RW'(9);
        #1;
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_gpr got=%0h/%0h/%0h exp=0/0/0", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
        checks++;
        if ({wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_csr got=%0h/%0h/%0h exp=0/0/0", wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o);
        end
        checks++;
        if (ll_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", ll_ready_o);
        end
        checks++;
        if ({reg1_pend_o, reg2_pend_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_pend got=%02b exp=00", {reg1_pend_o, reg2_pend_o});
        end
        idle();
    endtask

    task automatic test_as_write();
        logic [SW+CW:0] csr_exp;
`ifdef WB_CSR_WR_EN
        csr_exp = {1'b1, 12'h305, 32'h8000_0000};
`else
        csr_exp = '0;
`endif
        as_write(RW'(5), 32'h1234_5678);
        as_csr_wr_en_i    = 1'b1;
        as_csr_wr_adder_i = 12'h305;
        as_csr_wr_data_i  = 32'h8000_0000;
        tick();
        idle();
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            failures++;
            $display("FAIL as_gpr got=%0h/%0h/%0h exp=1/5/12345678", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
        checks++;
        if ({wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o} !== csr_exp) begin
            failures++;
            $display("FAIL as_csr got=%0h/%0h/%0h exp=%0h", wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o, csr_exp);
        end
        tick();
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b0, 5'd5, 32'h1234_5678}) begin
            failures++;
            $display("FAIL as_hold got=%0h/%0h/%0h exp=0/5/12345678", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
        checks++;
        if ({wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o} !== '0) begin
            failures++;
            $display("FAIL csr_idle got=%0h/%0h/%0h exp=0/0/0", wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o);
        end
    endtask

    task automatic test_ll_single();
        ll_issue_i       = 1'b1;
        ll_issue_adder_i = RW'(7);
        reg1_rd_adder_i  = RW'(7);
        tick();
        ll_issue_i = 1'b0;
        checks++;
        if (reg1_pend_o !== 1'b1) begin
            failures++;
            $display("FAIL ll_pend_set got=%0b exp=1", reg1_pend_o);
        end
        ll_result(RW'(7), 32'hDEAD_BEEF);
        #1;
        checks++;
        if (ll_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ll_ready got=%0b exp=1", ll_ready_o);
        end
        tick();
        ll_valid_i = 1'b0;
        checks++;
        if ({wb_reg_wr_en_o, reg1_pend_o} !== 2'b01) begin
            failures++;
            $display("FAIL ll_n1 got_en=%0b got_pend=%0b exp_en=0 exp_pend=1", wb_reg_wr_en_o, reg1_pend_o);
        end
        tick();
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL ll_n2 got=%0h/%0h/%0h exp=1/7/deadbeef", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
        checks++;
        if (reg1_pend_o !== 1'b0) begin
            failures++;
            $display("FAIL ll_pend_clr got=%0b exp=0", reg1_pend_o);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] exp_a [7];
        logic [CW-1:0] exp_d [7];
        logic          exp_r [7];
        exp_a = '{5'd10, 5'd11, 5'd12, 5'd3, 5'd13, 5'd4, 5'd5};
        exp_d = '{32'h10, 32'h11, 32'h12, 32'h33, 32'h13, 32'h44, 32'h55};
        exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            idle();
            case (i)
                0: begin as_write(RW'(10), 32'h10); ll_result(RW'(3), 32'h33); end
                1: begin as_write(RW'(11), 32'h11); ll_result(RW'(4), 32'h44); end
                2: begin as_write(RW'(12), 32'h12); ll_result(RW'(5), 32'h55); end
                3: ll_result(RW'(5), 32'h55);
                4: begin as_write(RW'(13), 32'h13); ll_result(RW'(5), 32'h55); end
                default: ;
            endcase
            tick();
            checks++;
            if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, exp_a[i], exp_d[i]}) begin
                failures++;
                $display("FAIL b2b_wr[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o, exp_a[i], exp_d[i]);
            end
            checks++;
            if (ll_ready_o !== exp_r[i]) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%0b exp=%0b", i, ll_ready_o, exp_r[i]);
            end
        end
        idle();
        tick();
        checks++;
        if (wb_reg_wr_en_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drained got=%0b exp=0", wb_reg_wr_en_o);
        end
    endtask

    task automatic test_wrap();
        ll_result(RW'(20), 32'hA000_0000);
        tick();
        for (int i = 1; i < 6; i++) begin
            ll_result(RW'(20 + i), 32'hA000_0000 + CW'(i));
            tick();
            checks++;
            if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, RW'(20 + i - 1), 32'hA000_0000 + CW'(i - 1)}) begin
                failures++;
                $display("FAIL wrap_wr[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o, RW'(20 + i - 1), 32'hA000_0000 + CW'(i - 1));
            end
            checks++;
            if (ll_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL wrap_ready[%0d] got=%0b exp=1", i, ll_ready_o);
            end
        end
        idle();
        tick();
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, 5'd25, 32'hA000_0005}) begin
            failures++;
            $display("FAIL wrap_last got=%0h/%0h/%0h exp=1/19/a0000005", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
    endtask

    task automatic test_pend_x0();
        ll_issue_i       = 1'b1;
        ll_issue_adder_i = RW'(9);
        reg2_rd_adder_i  = RW'(9);
        tick();
        ll_issue_i = 1'b0;
        ll_result(RW'(9), 32'h99);
        tick();
        ll_valid_i       = 1'b0;
        ll_issue_i       = 1'b1;
        ll_issue_adder_i = RW'(9);
        tick();
        ll_issue_i = 1'b0;
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, 5'd9, 32'h99}) begin
            failures++;
            $display("FAIL coll_wr got=%0h/%0h/%0h exp=1/9/99", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
        checks++;
        if (reg2_pend_o !== 1'b1) begin
            failures++;
            $display("FAIL coll_pend got=%0b exp=1", reg2_pend_o);
        end
        ll_issue_i       = 1'b1;
        ll_issue_adder_i = '0;
        ll_result('0, 32'hBAD);
        reg1_rd_adder_i  = '0;
        tick();
        idle();
        checks++;
        if (reg1_pend_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_pend got=%0b exp=0", reg1_pend_o);
        end
        tick();
        checks++;
        if (wb_reg_wr_en_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_nowrite got=%0b exp=0", wb_reg_wr_en_o);
        end
        ll_result(RW'(8), 32'h88);
        tick();
        idle();
        as_write('0, 32'hFFFF);
        tick();
        idle();
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o} !== {1'b1, 5'd8, 32'h88}) begin
            failures++;
            $display("FAIL as_x0_drain got=%0h/%0h/%0h exp=1/8/88", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o);
        end
    endtask

    task automatic test_reset_mid();
        as_write(RW'(17), 32'h17);
        ll_issue_i       = 1'b1;
        ll_issue_adder_i = RW'(16);
        ll_result(RW'(14), 32'hE);
        tick();
        ll_issue_i = 1'b0;
        ll_result(RW'(15), 32'hF);
        tick();
        ll_valid_i = 1'b0;
        checks++;
        if (ll_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_full got=%0b exp=0", ll_ready_o);
        end
        rst               = 1'b1;
        as_csr_wr_en_i    = 1'b1;
        as_csr_wr_adder_i = 12'h300;
        as_csr_wr_data_i  = 32'h5;
        tick();
        rst = 1'b0;
        idle();
        reg1_rd_adder_i = RW'(16);
        #1;
        checks++;
        if ({wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o, wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_outs got=%0h/%0h/%0h csr=%0h/%0h/%0h exp=all 0", wb_reg_wr_en_o, wb_reg_wr_adder_o, wb_reg_wr_data_o, wb_csr_wr_en_o, wb_csr_wr_adder_o, wb_csr_wr_data_o);
        end
        checks++;
        if ({ll_ready_o, reg1_pend_o} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_state got_ready=%0b got_pend=%0b exp_ready=1 exp_pend=0", ll_ready_o, reg1_pend_o);
        end
        tick();
        checks++;
        if (wb_reg_wr_en_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_discard got=%0b exp=0", wb_reg_wr_en_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        test_reset();
        test_as_write();
        test_ll_single();
        test_back_to_back();
        test_wrap();
        test_pend_x0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
